univ_shift_reg: RTL and testbench

- Parametrised successor to the team's single-bit D flip-flop with synchronous set/reset.
- Implements a WIDTH-bit universal register: hold, parallel load, shift and rotate in both directions, plus clear and set-all.
- A shift counter raises a one-cycle done pulse once WIDTH shift/rotate operations have completed since the last load.
- Used as the serialiser/deserialiser and general-purpose storage element in the team's datapath exercises.

---
 rtl/univ_shift_reg_pkg.sv | 21 ++
 rtl/shift_counter.sv | 44 ++++
 rtl/univ_shift_reg.sv | 110 +++++++++++
 tb/tb_univ_shift_reg.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/univ_shift_reg_pkg.sv
// Shared types and helpers for the universal shift register and its counter.
package univ_shift_reg_pkg;

    // Operation select for univ_shift_reg; every 3-bit code is a defined mode.
    typedef enum logic [2:0] {
        MODE_HOLD   = 3'b000,
        MODE_LOAD   = 3'b001,
        MODE_SHL    = 3'b010,
        MODE_SHR    = 3'b011,
        MODE_ROL    = 3'b100,
        MODE_ROR    = 3'b101,
        MODE_CLR    = 3'b110,
        MODE_SETALL = 3'b111
    } shr_mode_e;

    // Bits needed to count from 0 up to and including width.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_counter.sv
// Saturating shift counter with a registered one-cycle done pulse on the
// edge where the count first reaches the saturation value.
module shift_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          inc,
    input  logic [CW-1:0] sat,
    output logic [CW-1:0] cnt,
    output logic          done
);

    logic [CW-1:0] cnt_d, cnt_q;
    logic          done_d, done_q;

    // Next count: clear wins, otherwise count up until the saturation value.
    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && (cnt_q < sat)) begin
            cnt_d  = cnt_q + CW'(1);
            done_d = (cnt_d == sat);
        end
    end

    // Count and pulse registers; reset aborts any sequence without a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign cnt  = cnt_q;
    assign done = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal register: hold, load, shift/rotate both ways, clear and
// set-all, with a shift counter that pulses done after WIDTH shifts.
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     set,
    input  logic                     en,
    input  logic [2:0]               mode,
    input  logic [WIDTH-1:0]         d,
    input  logic                     sin_l,
    input  logic                     sin_r,
    output logic [WIDTH-1:0]         q,
    output logic                     sout_l,
    output logic                     sout_r,
    output logic [cnt_w(WIDTH)-1:0]  shift_cnt,
    output logic                     done
);

    localparam int CW = cnt_w(WIDTH);

    logic [WIDTH-1:0] q_d, q_q;
    logic             cnt_clear;
    logic             cnt_inc;
    shr_mode_e        mode_e;

    assign mode_e = shr_mode_e'(mode);

    // Next register value and counter control; concatenate-then-truncate
    // forms keep shifts/rotates legal for WIDTH=1 as well.
    always_comb begin
        q_d       = q_q;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        if (set) begin
            q_d       = '1;
            cnt_clear = 1'b1;
        end else if (en) begin
            case (mode_e)
                MODE_HOLD: q_d = q_q;
                MODE_LOAD: begin
                    q_d       = d;
                    cnt_clear = 1'b1;
                end
                MODE_SHL: begin
                    q_d     = WIDTH'({q_q, sin_l});
                    cnt_inc = 1'b1;
                end
                MODE_SHR: begin
                    q_d     = WIDTH'({sin_r, q_q} >> 1);
                    cnt_inc = 1'b1;
                end
                MODE_ROL: begin
                    q_d     = WIDTH'({q_q, q_q[WIDTH-1]});
                    cnt_inc = 1'b1;
                end
                MODE_ROR: begin
                    q_d     = WIDTH'({q_q[0], q_q} >> 1);
                    cnt_inc = 1'b1;
                end
                MODE_CLR: begin
                    q_d       = '0;
                    cnt_clear = 1'b1;
                end
                MODE_SETALL: begin
                    q_d       = '1;
                    cnt_clear = 1'b1;
                end
                default: q_d = q_q;
            endcase
        end
    end

    // Register contents; reset has top priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    // An unknown mode while enabled is a stimulus bug; the datapath holds.
    always_ff @(posedge clk) begin
        if (!rst && !set && en) begin
            assert (!$isunknown(mode));
        end
    end

    shift_counter #(
        .CW (CW)
    ) u_shift_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .sat   (CW'(WIDTH)),
        .cnt   (shift_cnt),
        .done  (done)
    );

    assign q      = q_q;
    assign sout_l = q_q[WIDTH-1];
    assign sout_r = q_q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg (WIDTH=8): each directed step pushes its
// hand-computed post-edge state; a monitor pops and compares on the falling edge.
module tb_univ_shift_reg;
    import univ_shift_reg_pkg::*;

    localparam int W  = 8;
    localparam int CW = cnt_w(W);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          set = 1'b0;
    logic          en = 1'b0;
    logic [2:0]    mode = 3'b000;
    logic [W-1:0]  d = '0;
    logic          sin_l = 1'b0;
    logic          sin_r = 1'b0;
    logic [W-1:0]  q;
    logic          sout_l;
    logic          sout_r;
    logic [CW-1:0] shift_cnt;
    logic          done;

    typedef struct {
        logic [W-1:0]  q;
        logic [CW-1:0] cnt;
        logic          done;
        string         name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    univ_shift_reg #(
        .WIDTH     (W),
        .RESET_VAL (8'h00)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .set       (set),
        .en        (en),
        .mode      (mode),
        .d         (d),
        .sin_l     (sin_l),
        .sin_r     (sin_r),
        .q         (q),
        .sout_l    (sout_l),
        .sout_r    (sout_r),
        .shift_cnt (shift_cnt),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Monitor: every falling edge with a pending expectation is a comparison.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if (q !== e.q || shift_cnt !== e.cnt || done !== e.done ||
                sout_l !== e.q[W-1] || sout_r !== e.q[0]) begin
                n_bad++;
                $display("FAIL %s: got q=%h cnt=%0d done=%b sout_l=%b sout_r=%b, want q=%h cnt=%0d done=%b sout_l=%b sout_r=%b",
                         e.name, q, shift_cnt, done, sout_l, sout_r,
                         e.q, e.cnt, e.done, e.q[W-1], e.q[0]);
            end
        end
    end

    // Drive one edge's inputs and record the state expected after that edge.
    task automatic step(input logic r, input logic s, input logic e,
                        input shr_mode_e m, input logic [W-1:0] dv,
                        input logic sl, input logic sr,
                        input logic [W-1:0] xq, input int xcnt, input logic xdone,
                        input string name);
        exp_t x;
        @(negedge clk);
        rst = r; set = s; en = e; mode = m; d = dv; sin_l = sl; sin_r = sr;
        @(posedge clk);
        x.q = xq; x.cnt = CW'(xcnt); x.done = xdone; x.name = name;
        exp_q.push_back(x);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a pending LOAD of all ones
        step(1, 0, 1, MODE_LOAD, 8'hFF, 0, 0, 8'h00, 0, 0, "reset_1");
        step(1, 0, 1, MODE_LOAD, 8'hFF, 0, 0, 8'h00, 0, 0, "reset_2");
        step(0, 0, 1, MODE_LOAD, 8'hFF, 0, 0, 8'hFF, 0, 0, "load_after_reset");

        // Set priority over en=0 and rst priority over set
        step(0, 0, 1, MODE_LOAD, 8'h3C, 0, 0, 8'h3C, 0, 0, "load_3c");
        step(0, 1, 0, MODE_SHL,  8'h00, 0, 0, 8'hFF, 0, 0, "set_over_en0");
        step(1, 1, 1, MODE_SHL,  8'h00, 0, 0, 8'h00, 0, 0, "rst_over_set");

        // Shift left to saturation with a single done pulse
        step(0, 0, 1, MODE_LOAD, 8'hA5, 0, 0, 8'hA5, 0, 0, "load_a5");
        step(0, 0, 1, MODE_SHL,  8'h00, 0, 0, 8'h4A, 1, 0, "shl_1");
        step(0, 0, 1, MODE_SHL,  8'h00, 0, 0, 8'h94, 2, 0, "shl_2");
        step(0, 0, 1, MODE_SHL,  8'h00, 0, 0, 8'h28, 3, 0, "shl_3");
        step(0, 0, 1, MODE_SHL,  8'h00, 0, 0, 8'h50, 4, 0, "shl_4");
        step(0, 0, 1, MODE_SHL,  8'h00, 0, 0, 8'hA0, 5, 0, "shl_5");
        step(0, 0, 1, MODE_SHL,  8'h00, 0, 0, 8'h40, 6, 0, "shl_6");
        step(0, 0, 1, MODE_SHL,  8'h00, 0, 0, 8'h80, 7, 0, "shl_7");
        step(0, 0, 1, MODE_SHL,  8'h00, 0, 0, 8'h00, 8, 1, "shl_8_done");
        step(0, 0, 1, MODE_SHL,  8'h00, 0, 0, 8'h00, 8, 0, "shl_9_saturated");

        // Rotates and serial outputs
        step(0, 0, 1, MODE_LOAD, 8'h81, 0, 0, 8'h81, 0, 0, "load_81");
        step(0, 0, 1, MODE_ROR,  8'h00, 0, 0, 8'hC0, 1, 0, "ror_1");
        step(0, 0, 1, MODE_ROL,  8'h00, 0, 0, 8'h81, 2, 0, "rol_1");
        step(0, 0, 1, MODE_ROL,  8'h00, 0, 0, 8'h03, 3, 0, "rol_2");

        // Enable gating
        step(0, 0, 1, MODE_LOAD, 8'h5A, 0, 0, 8'h5A, 0, 0, "load_5a");
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, MODE_SHR, 8'h00, 0, 1, 8'h5A, 0, 0, "en0_hold");
        step(0, 0, 1, MODE_SHR,  8'h00, 0, 1, 8'hAD, 1, 0, "shr_sin_r1");

        // Abort a sequence with CLR, then a full run of 8 shifts
        step(0, 0, 1, MODE_LOAD, 8'hF0, 0, 0, 8'hF0, 0, 0, "load_f0");
        step(0, 0, 1, MODE_SHR,  8'h00, 0, 0, 8'h78, 1, 0, "shr_a1");
        step(0, 0, 1, MODE_SHR,  8'h00, 0, 0, 8'h3C, 2, 0, "shr_a2");
        step(0, 0, 1, MODE_SHR,  8'h00, 0, 0, 8'h1E, 3, 0, "shr_a3");
        step(0, 0, 1, MODE_SHR,  8'h00, 0, 0, 8'h0F, 4, 0, "shr_a4");
        step(0, 0, 1, MODE_SHR,  8'h00, 0, 0, 8'h07, 5, 0, "shr_a5");
        step(0, 0, 1, MODE_CLR,  8'h00, 0, 0, 8'h00, 0, 0, "clr_abort");
        step(0, 0, 1, MODE_SHL,  8'h00, 1, 0, 8'h01, 1, 0, "shl_b1");
        step(0, 0, 1, MODE_SHL,  8'h00, 1, 0, 8'h03, 2, 0, "shl_b2");
        step(0, 0, 1, MODE_SHL,  8'h00, 1, 0, 8'h07, 3, 0, "shl_b3");
        step(0, 0, 1, MODE_SHL,  8'h00, 1, 0, 8'h0F, 4, 0, "shl_b4");
        step(0, 0, 1, MODE_SHL,  8'h00, 1, 0, 8'h1F, 5, 0, "shl_b5");
        step(0, 0, 1, MODE_SHL,  8'h00, 1, 0, 8'h3F, 6, 0, "shl_b6");
        step(0, 0, 1, MODE_SHL,  8'h00, 1, 0, 8'h7F, 7, 0, "shl_b7");
        step(0, 0, 1, MODE_SHL,  8'h00, 1, 0, 8'hFF, 8, 1, "shl_b8_done");

        // Remaining modes: load after done, explicit hold, set-all, set abort
        step(0, 0, 1, MODE_LOAD,   8'h11, 0, 0, 8'h11, 0, 0, "load_11");
        step(0, 0, 1, MODE_HOLD,   8'h00, 0, 0, 8'h11, 0, 0, "hold");
        step(0, 0, 1, MODE_SETALL, 8'h00, 0, 0, 8'hFF, 0, 0, "setall");
        step(0, 0, 1, MODE_SHR,    8'h00, 0, 0, 8'h7F, 1, 0, "shr_c1");
        step(0, 1, 1, MODE_SHR,    8'h00, 0, 0, 8'hFF, 0, 0, "set_abort");

        @(negedge clk);
        en = 1'b0;
        mode = MODE_HOLD;
        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
